// File: rtl/maxnet_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the Maxnet sequencer
// and its surroundings (start/done, memory, activation and stage controls).
interface maxnet_seq_ctrl_if #(
    parameter int N   = 4,
    parameter int AW  = 2,
    parameter int ITW = 4
);
    logic          start;
    logic [N-1:0]  nz_vec;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          act_sel;
    logic [N-1:0]  act_ld;
    logic          mul_en;
    logic          sum1_en;
    logic          sum2_en;
    logic          busy;
    logic          done;
    logic [AW-1:0] winner;
    logic          winner_valid;
    logic [ITW-1:0] iter_cnt;
    logic          timeout;

    modport slave (
        input  start, nz_vec,
        output mem_addr, mem_rd, act_sel, act_ld,
        output mul_en, sum1_en, sum2_en, busy, done,
        output winner, winner_valid, iter_cnt, timeout
    );

    modport master (
        output start, nz_vec,
        input  mem_addr, mem_rd, act_sel, act_ld,
        input  mul_en, sum1_en, sum2_en, busy, done,
        input  winner, winner_valid, iter_cnt, timeout
    );
endinterface

// File: rtl/maxnet_seq_ctrl.sv
// Maxnet sequencer: loads N activations, iterates inhibition until one survivor.
// Optional MAXNET_PRECHECK_EN: check survivors right after LOAD, before iterating.
module maxnet_seq_ctrl #(
    parameter int N        = 4,
    parameter int AW       = 2,
    parameter int MAX_ITER = 15,
    parameter int ITW      = 4
) (
    input  logic clk,
    input  logic rst,
    maxnet_seq_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MUL, S_SUM1,
        S_SUM2, S_UPDATE, S_CHECK, S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [AW-1:0]  r_ld_cnt;
    logic [ITW-1:0] r_iter;
    logic [AW-1:0]  r_winner;
    logic           r_wvalid;
    logic           r_timeout;
    logic [AW:0]    w_pop;
    logic [AW-1:0]  w_idx;
    logic           w_last_ld;
    logic           w_at_max;

    always_comb begin
        w_pop = '0;
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            w_pop = w_pop + {{AW{1'b0}}, bus.nz_vec[i]};
            if (bus.nz_vec[i]) w_idx = AW'(i);
        end
    end

    assign w_last_ld = (r_ld_cnt == AW'(N - 1));
    assign w_at_max  = (r_iter == ITW'(MAX_ITER));

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_next = bus.start ? S_LOAD : S_IDLE;
`ifdef MAXNET_PRECHECK_EN
            S_LOAD:   w_next = w_last_ld ? S_CHECK : S_LOAD;
`else
            S_LOAD:   w_next = w_last_ld ? S_MUL : S_LOAD;
`endif
            S_MUL:    w_next = S_SUM1;
            S_SUM1:   w_next = S_SUM2;
            S_SUM2:   w_next = S_UPDATE;
            S_UPDATE: w_next = S_CHECK;
            S_CHECK: begin
                if (w_pop <= 1 || w_at_max) w_next = S_DONE;
                else                        w_next = S_MUL;
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Moore decode: every control depends on the state register only
    always_comb begin
        bus.mem_addr = '0;
        bus.mem_rd   = 1'b0;
        bus.act_sel  = 1'b0;
        bus.act_ld   = '0;
        bus.mul_en   = 1'b0;
        bus.sum1_en  = 1'b0;
        bus.sum2_en  = 1'b0;
        bus.busy     = (r_state != S_IDLE);
        bus.done     = 1'b0;
        case (r_state)
            S_LOAD: begin
                bus.mem_rd   = 1'b1;
                bus.mem_addr = r_ld_cnt;
                bus.act_ld   = N'(1) << r_ld_cnt;
            end
            S_MUL:  bus.mul_en  = 1'b1;
            S_SUM1: bus.sum1_en = 1'b1;
            S_SUM2: begin
                bus.sum2_en = 1'b1;
                bus.act_sel = 1'b1;
            end
            S_UPDATE: begin
                bus.act_ld  = '1;
                bus.act_sel = 1'b1;
            end
            S_DONE:  bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ld_cnt  <= '0;
            r_iter    <= '0;
            r_winner  <= '0;
            r_wvalid  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ld_cnt  <= '0;
                        r_iter    <= '0;
                        r_timeout <= 1'b0;
                        r_wvalid  <= 1'b0;
                    end
                end
                S_LOAD: r_ld_cnt <= r_ld_cnt + 1'b1;
                S_UPDATE: begin
                    if (!w_at_max) r_iter <= r_iter + 1'b1;
                end
                S_CHECK: begin
                    if (w_pop == 1) begin
                        r_winner <= w_idx;
                        r_wvalid <= 1'b1;
                    end else if (w_pop == 0) begin
                        r_winner <= '0;
                        r_wvalid <= 1'b0;
                    end else if (w_at_max) begin
                        r_timeout <= 1'b1;
                        r_wvalid  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.winner       = r_winner;
    assign bus.winner_valid = r_wvalid;
    assign bus.iter_cnt     = r_iter;
    assign bus.timeout      = r_timeout;

endmodule

// File: tb/tb_maxnet_seq_ctrl.sv
// Directed self-checking bench for maxnet_seq_ctrl.
// Cycle k is the period after the k-th rising edge counted from start.
module tb_maxnet_seq_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    maxnet_seq_ctrl_if #(.N(4), .AW(2), .ITW(4)) bus ();

    maxnet_seq_ctrl #(.N(4), .AW(2), .MAX_ITER(15), .ITW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b,
                       input int sw, input bit extra,
                       input int exp_done, input logic [1:0] exp_w,
                       input logic exp_wv, input logic [3:0] exp_it,
                       input logic exp_to, input string nm);
        int dcyc = -1;
        int nmul = 0;
        bit ld_ok = 1'b1;
        cyc = 0;
        bus.nz_vec = a;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc <= 200 && dcyc < 0) begin
            if (cyc <= 4) begin
                if (!bus.mem_rd || bus.mem_addr != 2'(cyc - 1) ||
                    bus.act_ld != 4'(1 << (cyc - 1)) || bus.act_sel)
                    ld_ok = 1'b0;
            end
            if (bus.mul_en) nmul++;
            if (bus.done) dcyc = cyc;
            bus.nz_vec = (cyc <= sw) ? a : b;
            bus.start  = extra && (cyc == 3 || bus.done);
            if (dcyc < 0) tick();
        end
        checks++;
        if (dcyc !== exp_done) begin
            errors++;
            $display("FAIL %s done_cycle: got %0d want %0d", nm, dcyc, exp_done);
        end
        checks++;
        if (!ld_ok) begin
            errors++;
            $display("FAIL %s load_seq: got bad addr/rd/ld want addr 0..3 one-hot", nm);
        end
        checks++;
        if (nmul !== int'(exp_it)) begin
            errors++;
            $display("FAIL %s mul_pulses: got %0d want %0d", nm, nmul, exp_it);
        end
        checks++;
        if ({bus.winner, bus.winner_valid, bus.iter_cnt, bus.timeout, bus.busy}
            !== {exp_w, exp_wv, exp_it, exp_to, 1'b1}) begin
            errors++;
            $display("FAIL %s results: got w=%0d wv=%0b it=%0d to=%0b busy=%0b want w=%0d wv=%0b it=%0d to=%0b busy=1",
                     nm, bus.winner, bus.winner_valid, bus.iter_cnt, bus.timeout,
                     bus.busy, exp_w, exp_wv, exp_it, exp_to);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%0b busy=%0b want 0 0", nm, bus.done, bus.busy);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0 ||
            {bus.winner, bus.winner_valid, bus.iter_cnt, bus.timeout}
            !== {exp_w, exp_wv, exp_it, exp_to}) begin
            errors++;
            $display("FAIL %s idle_hold: got busy=%0b rd=%0b w=%0d wv=%0b it=%0d to=%0b",
                     nm, bus.busy, bus.mem_rd, bus.winner, bus.winner_valid,
                     bus.iter_cnt, bus.timeout);
        end
    endtask

    task automatic test_reset();
        bus.start  = 1'b0;
        bus.nz_vec = 4'b0000;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.mem_addr, bus.mem_rd, bus.act_sel, bus.act_ld, bus.mul_en,
             bus.sum1_en, bus.sum2_en, bus.busy, bus.done, bus.winner,
             bus.winner_valid, bus.iter_cnt, bus.timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b rd=%0b ld=%b it=%0d want all 0",
                     bus.busy, bus.mem_rd, bus.act_ld, bus.iter_cnt);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%0b want 0", bus.busy);
        end
    endtask

    task automatic test_reset_midrun();
        cyc = 0;
        bus.nz_vec = 4'b1111;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        while (cyc < 6) tick();
        checks++;
        if (bus.sum1_en !== 1'b1) begin
            errors++;
            $display("FAIL midrun_sum1: got sum1_en=%0b want 1", bus.sum1_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.mul_en, bus.sum1_en, bus.sum2_en, bus.mem_rd,
             bus.act_ld, bus.act_sel, bus.done, bus.iter_cnt} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%0b sum1=%0b ld=%b want 0",
                     bus.busy, bus.sum1_en, bus.act_ld);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        run(4'b0100, 4'b0100, 99, 1'b0, 10, 2'd2, 1'b1, 4'd1, 1'b0, "after_reset");
    endtask

    task automatic test_start_held();
        int dcyc = -1;
        cyc = 0;
        bus.nz_vec = 4'b0100;
        bus.start  = 1'b1;
        tick();
        while (cyc <= 200 && dcyc < 0) begin
            if (bus.done) dcyc = cyc;
            else tick();
        end
        checks++;
        if (dcyc !== 10) begin
            errors++;
            $display("FAIL held_first_done: got %0d want 10", dcyc);
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL held_gap: got busy=%0b rd=%0b want 0 0", bus.busy, bus.mem_rd);
        end
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 2'd0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL held_relaunch: got rd=%0b addr=%0d busy=%0b want 1 0 1",
                     bus.mem_rd, bus.mem_addr, bus.busy);
        end
        dcyc = -1;
        while (cyc <= 200 && dcyc < 0) begin
            if (bus.done) dcyc = cyc;
            else tick();
        end
        checks++;
        if (dcyc !== 21) begin
            errors++;
            $display("FAIL held_second_done: got %0d want 21", dcyc);
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        run(4'b0100, 4'b0100, 99, 1'b0, 10, 2'd2, 1'b1, 4'd1, 1'b0, "basic");
        run(4'b1111, 4'b1111, 999, 1'b0, 80, 2'd2, 1'b0, 4'd15, 1'b1, "timeout");
        run(4'b1011, 4'b0000, 9, 1'b0, 15, 2'd0, 1'b0, 4'd2, 1'b0, "suppressed");
        test_reset_midrun();
        run(4'b1000, 4'b1000, 99, 1'b1, 10, 2'd3, 1'b1, 4'd1, 1'b0, "ignore_start");
        test_start_held();
`ifdef MAXNET_PRECHECK_EN
        run(4'b0010, 4'b0010, 99, 1'b0, 6, 2'd1, 1'b1, 4'd0, 1'b0, "precheck");
`else
        run(4'b0010, 4'b0010, 99, 1'b0, 10, 2'd1, 1'b1, 4'd1, 1'b0, "min_iter");
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxnet_seq_ctrl.md
Name: maxnet_seq_ctrl

Overview:
- Sequencer for the N-neuron Maxnet datapath: loads the N initial activations from memory, then runs repeated mutual-inhibition iterations (MUL, SUM1, SUM2, write-back).
- Terminates when at most one activation is nonzero, or when the iteration budget is spent.
- Reports the winner index, the iteration count and a timeout flag.
- Sits between the top-level start/done handshake and the activation registers, operand muxes and arithmetic stages.

Parameters:
N, 4, number of neurons / activation registers.
AW, 2, memory address and winner index width; must satisfy 2**AW >= N.
MAX_ITER, 15, maximum number of inhibition iterations before timeout.
ITW, 4, iteration counter width; must hold MAX_ITER.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  run request; sampled only in IDLE.
nz_vec  in  N  bit i = 1 when activation register i is greater than 0 (datapath comparators).
mem_addr  out  AW  activation memory read address.
mem_rd  out  1  memory read strobe.
act_sel  out  1  activation input mux: 0 = memory data, 1 = updated value.
act_ld  out  N  per-register load enables.
mul_en, sum1_en, sum2_en  out  1 each  datapath stage enables.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle completion pulse.
winner  out  AW  index of the surviving neuron.
winner_valid  out  1  winner holds a unique survivor.
iter_cnt  out  ITW  completed iterations of the last or current run.
timeout  out  1  run ended because the MAX_ITER limit was reached.

Behaviour:
- Reset: state goes to IDLE immediately, including mid-run. All outputs are 0, and the load counter, iter_cnt, winner, winner_valid and timeout are cleared.
- States: IDLE, LOAD, MUL, SUM1, SUM2, UPDATE, CHECK, DONE. Moore outputs are decoded from the state register only; all other outputs are 0 unless listed.
- IDLE: start=1 moves to LOAD and clears the load counter, iter_cnt, timeout and winner_valid. winner, winner_valid, iter_cnt and timeout otherwise hold their last values.
- LOAD: lasts N cycles with load counter i = 0..N-1.
  - mem_rd=1, mem_addr=i, act_sel=0, act_ld = one-hot(i).
  - Memory read is combinational: data is valid in the same cycle.
  - After i = N-1 the next state is MUL.
- MUL: mul_en=1, then SUM1.
- SUM1: sum1_en=1, then SUM2.
- SUM2: sum2_en=1, act_sel=1, then UPDATE.
- UPDATE: act_ld = all ones, act_sel=1, iter_cnt increments, then CHECK.
- CHECK: evaluates nz_vec, which now reflects the post-update registers. Let p = popcount(nz_vec).
  - p == 1: winner = index of the set bit, winner_valid=1, go to DONE.
  - p == 0: winner=0, winner_valid=0, go to DONE (all neurons suppressed).
  - p >= 2 and iter_cnt == MAX_ITER: timeout=1, winner_valid=0, go to DONE.
  - otherwise: go to MUL.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE unconditionally.
- start while busy, including in DONE, is ignored and not queued. start held high launches a new run from IDLE on the cycle after DONE.
- Latency, with start sampled at edge 0: LOAD covers cycles 1..N, each iteration takes 5 cycles, and done is high in cycle N + 5*iters + 1.
- iter_cnt never exceeds MAX_ITER and never wraps.
- Undefined state encodings fall to IDLE.

Optional Feature:
- Macro: MAXNET_PRECHECK_EN.
- When defined: LOAD exits to CHECK instead of MUL. A run whose initial nz_vec already has p <= 1 finishes with iter_cnt=0 and done in cycle N+2. If p >= 2 at this pre-check, the timeout test does not apply (iter_cnt=0) and the flow proceeds to MUL.
- When undefined: every run performs at least one iteration.

Test Plan:
1. N=4, start at edge 0; bench drives nz_vec=4'b0100 after the first UPDATE -> mem_addr 0,1,2,3 in cycles 1-4; done in cycle 10; winner=2, winner_valid=1, iter_cnt=1, timeout=0.
2. nz_vec held at 4'b1111 -> 15 iterations; done in cycle 80; timeout=1, winner_valid=0, iter_cnt=15.
3. nz_vec goes 1011 after iteration 1, then 0000 after iteration 2 -> done in cycle 15; winner_valid=0, timeout=0, iter_cnt=2.
4. rst pulsed during SUM1 of iteration 1 -> same cycle: busy=0 and all enables 0; a later start runs scenario 1 timing exactly.
5. start pulsed in cycle 3 (during LOAD) and in the DONE cycle -> both ignored, single done pulse; start held high continuously -> second run's LOAD begins 2 cycles after the first done.
6. MAXNET_PRECHECK_EN defined, nz_vec=4'b0010 during load -> done in cycle 6; winner=1, winner_valid=1, iter_cnt=0; no mul_en pulses.
